uart_rx_to_axis: RTL
====================

Name: uart_rx_to_axis

Overview:
- UART receiver: 8N1 serial frames on `rxd` are deserialised and presented as bytes on an AXI-Stream master port.
- Counterpart of the existing AXIS-to-UART transmitter: same clock domain (clk125), same baud-divider convention, same LSB-first 8N1 framing.
- Sits between the board RX pin and any byte-stream consumer, e.g. a command parser or loopback FIFO.

Parameters:
- BaudRateDivider, 1085, clk125 cycles per bit (1085 gives 115200 baud at 125 MHz). Legal range 4..65535.

Ports:
- clk125  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rxd  input  1  asynchronous serial input, idle high.
- axis_tdata  output  8  received byte.
- axis_tvalid  output  1  byte available.
- axis_tready  input  1  consumer accepts byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte lost because output register still full.

Behaviour:
- Reset (asynchronous, active-high) applies these values immediately on assertion:
  - axis_tvalid=0, axis_tdata=0, frame_err=0, overrun=0.
  - State=IDLE, bit counter=0, delay counter=0.
  - Synchroniser flops preset to 1, so deassertion never produces a false start.
- Reset mid-frame abandons the frame and discards any pending byte.
- rxd passes through a 2-flop synchroniser; rxd_s is its output. The synchroniser adds 2 cycles of latency, and all timing below is relative to rxd_s.
- Delay counter is 16 bits and counts down to 0. Sampling happens on the cycle the counter reads 0.
- Let half = BaudRateDivider/2 (integer division). T0 is the first cycle rxd_s=0 while in IDLE.
- States:
  - IDLE: on rxd_s=0, load delay=half-1 and go to START. Otherwise stay.
  - START: at expiry, if rxd_s=0, load delay=BaudRateDivider-1, set bit=0 and go to DATA. If rxd_s=1, the start was a glitch: return to IDLE, no output, no flag.
  - DATA: at each expiry, shift rxd_s into the MSB of the shift register (LSB-first reception). If bit=7, go to STOP; otherwise bit++. Reload delay=BaudRateDivider-1 on every expiry.
  - STOP: at expiry, if rxd_s=1, deliver the byte and go to IDLE. If rxd_s=0, pulse frame_err, drop the byte and go to BREAK.
  - BREAK: wait for rxd_s=1, then go to IDLE. A held-low line (break) yields exactly one frame_err and no bytes.
- Sample instants:
  - Start check at T0+half.
  - Data bit k (0..7) at T0+half+(k+1)·BaudRateDivider.
  - Stop bit at T0+half+9·BaudRateDivider.
- Delivery:
  - If axis_tvalid=0, or axis_tvalid=1 with axis_tready=1 in the same cycle, load axis_tdata and set axis_tvalid=1 on the next edge.
  - Otherwise keep the old byte, drop the new one, and pulse overrun for one cycle.
- Handshake:
  - axis_tvalid stays high and axis_tdata stays stable until the transfer completes (axis_tvalid & axis_tready).
  - axis_tvalid clears after the transfer unless a new byte is loaded in the same cycle.
  - axis_tvalid never depends combinationally on axis_tready.
- Returning to IDLE at mid-stop-bit lets back-to-back frames, with no idle gap, be received without loss.
- frame_err and overrun are registered single-cycle pulses and are never high simultaneously.

Test Plan (BaudRateDivider=16 for simulation):
- Send 0x55 8N1 with axis_tready=1 → axis_tvalid high for exactly 1 cycle with axis_tdata=0x55; frame_err=0, overrun=0.
- Send 0xA3, 0x0F, 0xFF back-to-back with no idle gap and axis_tready=1 → three beats 0xA3, 0x0F, 0xFF in order; no flags.
- Hold axis_tready=0 and send 0x12 then 0x34 → axis_tdata stays 0x12 and one overrun pulse occurs at the second stop sample. Then raise axis_tready → only 0x12 transfers; axis_tvalid then drops.
- Send 0xC6 with the stop bit driven low, then hold rxd low for 40 bit times, then send 0x7E → exactly one frame_err pulse and no beat for the bad frame; 0x7E is then received correctly.
- Drive a 4-cycle low glitch on idle rxd → no axis_tvalid, no flags, state returns to IDLE; a following 0x81 is received correctly.
- Assert reset mid-way through data bit 4 of a frame with an undelivered byte pending → axis_tvalid drops immediately and the partial frame produces no output. After release, a fresh 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_rx_to_axis.sv
// UART 8N1 receiver presenting each received byte on an AXI-Stream master port.
// Mid-bit sampling is driven by a 16-bit down-counter reloaded from BaudRateDivider.
module uart_rx_to_axis #(
    parameter int BaudRateDivider = 1085
) (
    input  logic       clk125,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] axis_tdata,
    output logic       axis_tvalid,
    input  logic       axis_tready,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [15:0] FULL_M1 = 16'(BaudRateDivider - 1);
    localparam logic [15:0] HALF_M1 = 16'(BaudRateDivider / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_sync;
    logic        w_rxd_s;
    logic [15:0] r_delay;
    logic [15:0] w_delay_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        w_expired;
    logic        w_deliver;
    logic        w_ferr;
    logic [7:0]  r_tdata;
    logic        r_tvalid;
    logic        r_ferr;
    logic        r_ovr;

    assign w_rxd_s   = r_sync[1];
    assign w_expired = (r_delay == 16'd0);

    // Two-flop synchroniser, preset high so reset release never looks like a start bit
    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], rxd};
    end

    // Receiver state, bit index, sample timer and shift register
    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_delay <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_delay <= w_delay_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic: samples are taken on the cycle the timer reads zero
    always_comb begin
        w_state_nxt = r_state;
        w_delay_nxt = w_expired ? r_delay : r_delay - 16'd1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rxd_s) begin
                    w_state_nxt = S_START;
                    w_delay_nxt = HALF_M1;
                end
            end
            S_START: begin
                if (w_expired) begin
                    if (!w_rxd_s) begin
                        w_state_nxt = S_DATA;
                        w_delay_nxt = FULL_M1;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_expired) begin
                    w_shift_nxt = {w_rxd_s, r_shift[7:1]};
                    w_delay_nxt = FULL_M1;
                    if (r_bit == 3'd7) w_state_nxt = S_STOP;
                    else               w_bit_nxt   = r_bit + 3'd1;
                end
            end
            S_STOP: begin
                if (w_expired) begin
                    if (w_rxd_s) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (w_rxd_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output register: load when empty or draining, otherwise drop and flag overrun
    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            r_tdata  <= 8'd0;
            r_tvalid <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= 1'b0;
            if (w_deliver) begin
                if (!r_tvalid || axis_tready) begin
                    r_tdata  <= r_shift;
                    r_tvalid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign axis_tdata  = r_tdata;
    assign axis_tvalid = r_tvalid;
    assign frame_err   = r_ferr;
    assign overrun     = r_ovr;

endmodule
